// File: rtl/fullchip_seq_ctrl.sv
// Job sequencer producing the 17-bit fullchip instruction word: Q write, K write, K load, execute, ofifo->pmem move.
// Optional K reuse path is enabled by defining FULLCHIP_SEQ_KREUSE_EN.
module fullchip_seq_ctrl #(
  parameter int bw          = 8,
  parameter int pr          = 16,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int WAIT_CYC    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef FULLCHIP_SEQ_KREUSE_EN
  input  logic             k_reuse,
`endif
  input  logic [pr*bw-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [pr*bw-1:0] mem_in,
  output logic [16:0]      inst,
  output logic             busy,
  output logic             done,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_GAP, S_KLOAD, S_WAITK, S_EXEC, S_WAITE, S_MOVE, S_DONE
  } state_t;

  localparam logic [7:0] LAST_Q  = 8'(total_cycle - 1);
  localparam logic [7:0] LAST_K  = 8'(col - 1);
  localparam logic [7:0] LAST_LD = 8'(col + 1);
  localparam logic [7:0] LAST_W  = 8'(WAIT_CYC - 1);
  localparam logic [7:0] K_LAST  = 8'(col);

  state_t     state;
  logic [7:0] cnt;
  logic       skip_k;

`ifdef FULLCHIP_SEQ_KREUSE_EN
  logic reuse_job;
  logic k_loaded;
  assign skip_k = reuse_job;
`else
  assign skip_k = 1'b0;
`endif

  // Handshake: a data_in beat transfers on a rising edge where data_valid && data_ready.
  assign data_ready = (state == S_QWR) || (state == S_KWR);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      inst   <= '0;
      mem_in <= '0;
`ifdef FULLCHIP_SEQ_KREUSE_EN
      reuse_job <= 1'b0;
      k_loaded  <= 1'b0;
`endif
    end else begin
      inst <= '0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= S_QWR;
`ifdef FULLCHIP_SEQ_KREUSE_EN
            reuse_job <= k_reuse && k_loaded;
`endif
          end
        end
        S_QWR: begin
          if (data_valid) begin
            inst[4]     <= 1'b1;
            inst[15:12] <= cnt[3:0];
            mem_in      <= data_in;
            if (cnt == LAST_Q) begin
              cnt   <= '0;
              state <= skip_k ? S_EXEC : S_KWR;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        S_KWR: begin
          if (data_valid) begin
            inst[2]     <= 1'b1;
            inst[15:12] <= cnt[3:0];
            mem_in      <= data_in;
            if (cnt == LAST_K) begin
              cnt   <= '0;
              state <= S_GAP;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        S_GAP: begin
          if (cnt == 8'd1) begin
            cnt   <= '0;
            state <= S_KLOAD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_KLOAD: begin
          inst[6] <= 1'b1;
          // First and last load cycles frame the col kmem reads.
          if (cnt >= 8'd1 && cnt <= K_LAST) begin
            inst[3]     <= 1'b1;
            inst[15:12] <= 4'(cnt - 8'd1);
          end
          if (cnt == LAST_LD) begin
            cnt   <= '0;
            state <= S_WAITK;
`ifdef FULLCHIP_SEQ_KREUSE_EN
            k_loaded <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAITK, S_WAITE: begin
          if (cnt == LAST_W) begin
            cnt   <= '0;
            state <= (state == S_WAITK) ? S_EXEC : S_MOVE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_EXEC: begin
          inst[7]     <= 1'b1;
          inst[5]     <= 1'b1;
          inst[15:12] <= cnt[3:0];
          if (cnt == LAST_Q) begin
            cnt   <= '0;
            state <= S_WAITE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_MOVE: begin
          inst[16]   <= 1'b1;
          inst[0]    <= 1'b1;
          inst[11:8] <= cnt[3:0];
          if (cnt == LAST_Q) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fullchip_seq_ctrl.sv
// Bench for fullchip_seq_ctrl: builds the expected per-cycle job trace from the sequencing rules and
// compares inst, mem_in, data_ready, busy and done every cycle.
module tb_fullchip_seq_ctrl;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] data_in;
  logic [W-1:0] mem_in;
  logic [16:0]  inst;
  logic [3:0]   state_dbg;
`ifdef FULLCHIP_SEQ_KREUSE_EN
  logic         k_reuse;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [16:0]  inst;   // inst expected on the cycle after this one
    logic [W-1:0] mem;    // mem_in expected on the cycle after this one
    logic         valid;
    logic [W-1:0] data;
    logic         rdy;
    logic         bsy;
    logic         dn;
  } cyc_t;

  cyc_t         job_q[$];
  logic [W-1:0] model_mem;
  bit           model_k_loaded;
  int           exec_idx;

  fullchip_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef FULLCHIP_SEQ_KREUSE_EN
    .k_reuse    (k_reuse),
`endif
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .mem_in     (mem_in),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void push(input logic [16:0] w, input logic v, input logic rdy,
                               input logic bsy, input logic dn);
    cyc_t c;
    c.inst  = w;
    c.valid = v;
    c.data  = rand_word();
    c.rdy   = rdy;
    c.bsy   = bsy;
    c.dn    = dn;
    if (v && rdy) model_mem = c.data;
    c.mem = model_mem;
    job_q.push_back(c);
  endfunction

  function automatic logic rv();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace for one job, one entry per cycle starting with the first QWR cycle.
  function automatic void build_job(input bit reuse, input bit stall);
    int n;
    int i;
    logic v;
    logic [16:0] w;
    job_q.delete();
    n = 0;
    i = 0;
    while (n < 8) begin
      v = (stall && i < 3) ? logic'(i != 1) : logic'($urandom_range(0, 3) != 0);
      push(v ? 17'(32'h10 | (n << 12)) : 17'h0, v, 1'b1, 1'b1, 1'b0);
      n += int'(v);
      i++;
    end
    if (!reuse) begin
      n = 0;
      while (n < 8) begin
        v = logic'($urandom_range(0, 3) != 0);
        push(v ? 17'(32'h4 | (n << 12)) : 17'h0, v, 1'b1, 1'b1, 1'b0);
        n += int'(v);
      end
      for (int g = 0; g < 2; g++) push(17'h0, rv(), 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) begin
        w = 17'h40;
        if (c >= 1 && c <= 8) w = w | 17'(32'h8 | ((c - 1) << 12));
        push(w, rv(), 1'b0, 1'b1, 1'b0);
      end
      model_k_loaded = 1'b1;
      for (int k = 0; k < 10; k++) push(17'h0, rv(), 1'b0, 1'b1, 1'b0);
    end
    exec_idx = job_q.size();
    for (int e = 0; e < 8; e++) push(17'(32'hA0 | (e << 12)), rv(), 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) push(17'h0, rv(), 1'b0, 1'b1, 1'b0);
    for (int m = 0; m < 8; m++) push(17'(32'h10001 | (m << 8)), rv(), 1'b0, 1'b1, 1'b0);
    push(17'h0, rv(), 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) push(17'h0, rv(), 1'b0, 1'b0, 1'b0);
  endfunction

  // Entered and left at a negedge while the DUT is idle.
  task automatic run_job(input bit stall, input bit abort, input bit reuse_req);
    bit reuse;
    int abort_at;
`ifdef FULLCHIP_SEQ_KREUSE_EN
    reuse   = reuse_req && model_k_loaded;
    k_reuse = reuse_req;
`else
    reuse = 1'b0 & reuse_req;
`endif
    build_job(reuse, stall);
    abort_at = abort ? exec_idx + 3 : -1;
    start      = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < job_q.size(); i++) begin
      chk("data_ready", W'(data_ready), W'(job_q[i].rdy));
      chk("busy", W'(busy), W'(job_q[i].bsy));
      chk("done", W'(done), W'(job_q[i].dn));
      if (i > 0) begin
        chk("inst", W'(inst), W'(job_q[i-1].inst));
        chk("mem_in", mem_in, job_q[i-1].mem);
      end
      if (i == abort_at) begin
        reset      = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        chk("abort_inst", W'(inst), '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_ready", W'(data_ready), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_mem", mem_in, '0);
        reset          = 1'b0;
        model_mem      = '0;
        model_k_loaded = 1'b0;
        return;
      end
      data_valid = job_q[i].valid;
      data_in    = job_q[i].data;
      start      = job_q[i].bsy ? rv() : 1'b0;
`ifdef FULLCHIP_SEQ_KREUSE_EN
      k_reuse    = rv();
`endif
      @(negedge clk);
    end
    start      = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
`ifdef FULLCHIP_SEQ_KREUSE_EN
    k_reuse    = 1'b0;
`endif
    model_mem      = '0;
    model_k_loaded = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inst", W'(inst), '0);
    chk("rst_mem", mem_in, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_ready", W'(data_ready), '0);
    chk("rst_done", W'(done), '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", W'(busy), '0);

    run_job(1'b1, 1'b0, 1'b0);  // full job with 1,0,1 valid pattern at the start of QWR
    run_job(1'b0, 1'b1, 1'b0);  // reset during EXEC
    run_job(1'b0, 1'b0, 1'b1);  // reuse requested without loaded K: full path
    run_job(1'b0, 1'b0, 1'b1);  // reuse with loaded K (short path when enabled)
    run_job(1'b0, 1'b0, 1'b0);
    run_job(1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
